// File: rtl/ss_sequencer_pkg.sv
// Shared definitions for the save-state sequencer: state encoding, address
// width and the bit positions of the ss_act / ss_we bus controls.
package ss_sequencer_pkg;

  localparam int SS_AW      = 8;
  localparam int SS_ACT_BIT = 0;
  localparam int SS_WE_BIT  = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SV_ADDR  = 3'd1,
    SV_CAP   = 3'd2,
    LD_FETCH = 3'd3,
    LD_DRIVE = 3'd4,
    LD_WAIT  = 3'd5,
    LD_HOLD  = 3'd6,
    FIN      = 3'd7
  } state_t;

  // Final address of a walk of len entries; len=256 gives 255, so the walk
  // terminates on a compare rather than relying on counter wrap.
  function automatic logic [SS_AW-1:0] last_addr(input int len);
    return SS_AW'(len - 1);
  endfunction

endpackage

// File: rtl/ss_sequencer_m2_edge.sv
// Brings the asynchronous CPU M2 into the clk domain and flags its falling
// edge as a one-cycle pulse.
module ss_sequencer_m2_edge
  import ss_sequencer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic m2,
  output logic fall
);

  // [0] first sync stage, [1] second sync stage, [2] second stage delayed
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], m2};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign fall = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ss_sequencer.sv
// Save-state sequencer: copies mapper save-state bytes into a buffer (save)
// or writes buffered bytes back into the mapper around an M2 fall (load).
module ss_sequencer
  import ss_sequencer_pkg::*;
#(
  parameter int SS_LEN = 128,
  parameter int SETTLE = 2,
  parameter int M2_TMO = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m2,
  input  logic             start_save,
  input  logic             start_load,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             ss_act,
  output logic             ss_we,
  output logic [SS_AW-1:0] ss_addr,
  output logic [SS_AW-1:0] ss_dat,
  input  logic [SS_AW-1:0] ss_rdat,
  output logic [7:0]       buf_addr,
  output logic [7:0]       buf_wdat,
  output logic             buf_we,
  input  logic [7:0]       buf_rdat
);

  localparam logic [SS_AW-1:0] LAST = last_addr(SS_LEN);
  localparam int STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int TW  = $clog2(M2_TMO + 1);
  localparam logic [STW-1:0] SETTLE_LAST = STW'(SETTLE - 1);
  localparam logic [TW-1:0]  TMO_LAST    = TW'(M2_TMO - 1);
  // A fall seen in the first two LD_WAIT cycles may stem from an M2 edge
  // that happened before ss_we rose, so it is not accepted.
  localparam logic [TW-1:0]  TMO_ARM     = TW'(2);

  state_t           state_q, state_d;
  logic [SS_AW-1:0] cnt_q, cnt_d;
  logic [STW-1:0]   settle_q, settle_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [1:0]       ctl_q, ctl_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [SS_AW-1:0] ss_addr_q, ss_addr_d;
  logic [SS_AW-1:0] ss_dat_q, ss_dat_d;
  logic [7:0]       buf_addr_q, buf_addr_d;
  logic [7:0]       buf_wdat_q, buf_wdat_d;
  logic             buf_we_q, buf_we_d;
  logic             m2_fall;

  ss_sequencer_m2_edge u_m2_edge (
    .clk  (clk),
    .rst  (rst),
    .m2   (m2),
    .fall (m2_fall)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    settle_d   = settle_q;
    tmo_d      = tmo_q;
    ctl_d      = ctl_q;
    done_d     = 1'b0;
    err_d      = err_q;
    ss_addr_d  = ss_addr_q;
    ss_dat_d   = ss_dat_q;
    buf_addr_d = buf_addr_q;
    buf_wdat_d = buf_wdat_q;
    buf_we_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_save) begin
          err_d             = 1'b0;
          cnt_d             = '0;
          settle_d          = '0;
          ss_addr_d         = '0;
          ctl_d[SS_ACT_BIT] = 1'b1;
          state_d           = SV_ADDR;
        end else if (start_load) begin
          err_d             = 1'b0;
          cnt_d             = '0;
          ss_addr_d         = '0;
          buf_addr_d        = '0;
          ctl_d[SS_ACT_BIT] = 1'b1;
          state_d           = LD_FETCH;
        end
      end

      SV_ADDR: begin
        if (settle_q == SETTLE_LAST) begin
          buf_we_d   = 1'b1;
          buf_addr_d = cnt_q;
          buf_wdat_d = ss_rdat;
          state_d    = SV_CAP;
        end else begin
          settle_d = settle_q + STW'(1);
        end
      end

      SV_CAP: begin
        if (cnt_q == LAST) begin
          ctl_d   = '0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          ss_addr_d = cnt_q + 8'd1;
          settle_d  = '0;
          state_d   = SV_ADDR;
        end
      end

      LD_FETCH: state_d = LD_DRIVE;

      LD_DRIVE: begin
        ss_dat_d         = buf_rdat;
        ctl_d[SS_WE_BIT] = 1'b1;
        tmo_d            = '0;
        state_d          = LD_WAIT;
      end

      LD_WAIT: begin
        if (m2_fall && (tmo_q >= TMO_ARM)) begin
          state_d = LD_HOLD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          ctl_d   = '0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      LD_HOLD: begin
        ctl_d[SS_WE_BIT] = 1'b0;
        if (cnt_q == LAST) begin
          ctl_d   = '0;
          done_d  = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d      = cnt_q + 8'd1;
          ss_addr_d  = cnt_q + 8'd1;
          buf_addr_d = cnt_q + 8'd1;
          state_d    = LD_FETCH;
        end
      end

      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      settle_q   <= '0;
      tmo_q      <= '0;
      ctl_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ss_addr_q  <= '0;
      ss_dat_q   <= '0;
      buf_addr_q <= '0;
      buf_wdat_q <= '0;
      buf_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      ctl_q      <= ctl_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ss_addr_q  <= ss_addr_d;
      ss_dat_q   <= ss_dat_d;
      buf_addr_q <= buf_addr_d;
      buf_wdat_q <= buf_wdat_d;
      buf_we_q   <= buf_we_d;
    end
  end

  assign busy     = ctl_q[SS_ACT_BIT];
  assign ss_act   = ctl_q[SS_ACT_BIT];
  assign ss_we    = ctl_q[SS_WE_BIT];
  assign done     = done_q;
  assign err      = err_q;
  assign ss_addr  = ss_addr_q;
  assign ss_dat   = ss_dat_q;
  assign buf_addr = buf_addr_q;
  assign buf_wdat = buf_wdat_q;
  assign buf_we   = buf_we_q;

endmodule

// File: tb/tb_ss_sequencer.sv
// Directed bench for ss_sequencer: save, load with a latching mapper model,
// M2 timeout, start collisions, reset mid-load and a 256-entry save walk.
module tb_ss_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, m2, start_save, start_load;
  logic       busy, done, err, ss_act, ss_we, buf_we;
  logic [7:0] ss_addr, ss_dat, ss_rdat, buf_addr, buf_wdat, buf_rdat;

  logic       start_save2, start_load2;
  logic       busy2, done2, err2, ss_act2, ss_we2, buf_we2;
  logic [7:0] ss_addr2, ss_dat2, ss_rdat2, buf_addr2, buf_wdat2, buf_rdat2;

  ss_sequencer dut (
    .clk(clk), .rst(rst), .m2(m2),
    .start_save(start_save), .start_load(start_load),
    .busy(busy), .done(done), .err(err), .ss_act(ss_act), .ss_we(ss_we),
    .ss_addr(ss_addr), .ss_dat(ss_dat), .ss_rdat(ss_rdat),
    .buf_addr(buf_addr), .buf_wdat(buf_wdat), .buf_we(buf_we), .buf_rdat(buf_rdat)
  );

  ss_sequencer #(.SS_LEN(256)) dut2 (
    .clk(clk), .rst(rst), .m2(m2),
    .start_save(start_save2), .start_load(start_load2),
    .busy(busy2), .done(done2), .err(err2), .ss_act(ss_act2), .ss_we(ss_we2),
    .ss_addr(ss_addr2), .ss_dat(ss_dat2), .ss_rdat(ss_rdat2),
    .buf_addr(buf_addr2), .buf_wdat(buf_wdat2), .buf_we(buf_we2), .buf_rdat(buf_rdat2)
  );

  assign ss_rdat   = ss_addr ^ 8'h5A;
  assign ss_rdat2  = ss_addr2 ^ 8'h5A;
  assign buf_rdat2 = 8'h00;

  // M2 at clk/8, phase-offset from clk; can be frozen at a level
  logic m2_run = 1'b0;
  logic m2_lvl = 1'b0;
  initial begin
    m2 = 1'b0;
    #3;
    forever begin
      #40;
      m2 = m2_run ? ~m2 : m2_lvl;
    end
  end

  // Buffer model with synchronous read, plus a preload port
  logic [7:0] buf_mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = 8'h00, pre_dat = 8'h00;
  always @(posedge clk) begin
    if (pre_we) buf_mem[pre_addr] <= pre_dat;
    else if (buf_we) buf_mem[buf_addr] <= buf_wdat;
    buf_rdat <= buf_mem[buf_addr];
  end

  // Mapper model latching on the M2 falling edge
  logic [7:0] map_mem [256];
  int map_writes = 0;
  always @(negedge m2) begin
    if (ss_act && ss_we) begin
      map_mem[ss_addr] <= ss_dat;
      map_writes <= map_writes + 1;
    end
  end

  int bw_cnt = 0, done_cnt = 0, we_rises = 0, stab_viol = 0, win_viol = 0, snap = 0;
  int bw2_cnt = 0, bw2_bad = 0, done2_cnt = 0;
  logic       we_prev = 1'b0, mon_load = 1'b0;
  logic [7:0] addr_prev = 8'h00, dat_prev = 8'h00;
  always @(negedge clk) begin
    if (buf_we) bw_cnt <= bw_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (ss_we && !we_prev) begin
      we_rises <= we_rises + 1;
      snap <= map_writes;
    end
    if (mon_load && ss_we && we_prev && (ss_addr != addr_prev || ss_dat != dat_prev))
      stab_viol <= stab_viol + 1;
    if (mon_load && !ss_we && we_prev && !err && map_writes == snap)
      win_viol <= win_viol + 1;
    we_prev   <= ss_we;
    addr_prev <= ss_addr;
    dat_prev  <= ss_dat;
    if (buf_we2) begin
      bw2_cnt <= bw2_cnt + 1;
      if (buf_addr2 != 8'(bw2_cnt) || buf_wdat2 != (8'(bw2_cnt) ^ 8'h5A))
        bw2_bad <= bw2_bad + 1;
    end
    if (done2) done2_cnt <= done2_cnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_save();
    @(negedge clk);
    start_save = 1'b1;
    @(negedge clk);
    start_save = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int e, d0, b0, w0, mw0, bad;

  initial begin
    rst = 1'b1; start_save = 1'b0; start_load = 1'b0;
    start_save2 = 1'b0; start_load2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_outs", 64'({busy, done, err, ss_act, ss_we, buf_we,
                             ss_addr, ss_dat, buf_addr, buf_wdat}), 64'd0);
    check("reset_outs2", 64'({busy2, done2, err2, ss_act2, ss_we2, buf_we2, ss_addr2}), 64'd0);

    // Save of 128 entries: SS_LEN*(SETTLE+1)+1 = 385 cycles to done
    repeat (2) @(negedge clk);
    d0 = done_cnt; b0 = bw_cnt;
    pulse_save();
    check("save_busy", 64'({busy, ss_act}), 64'd3);
    e = 1;
    while (!done && e < 2000) begin @(negedge clk); e++; end
    check("save_cycles", 64'(e), 64'd385);
    check("save_fin_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("save_bw_cnt", 64'(bw_cnt - b0), 64'd128);
    check("save_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("save_err", 64'(err), 64'd0);
    bad = 0;
    for (int a = 0; a < 128; a++) if (buf_mem[8'(a)] !== (8'(a) ^ 8'h5A)) bad++;
    check("save_buf_bad", 64'(bad), 64'd0);
    check("save_buf0", 64'(buf_mem[0]), 64'h5A);
    check("save_buf127", 64'(buf_mem[127]), 64'h25);

    // Save with SS_LEN=256: 769 cycles, 256 writes, no restart after wrap
    @(negedge clk); start_save2 = 1'b1;
    @(negedge clk); start_save2 = 1'b0;
    e = 1;
    while (!done2 && e < 2000) begin @(negedge clk); e++; end
    check("s256_cycles", 64'(e), 64'd769);
    repeat (20) @(negedge clk);
    check("s256_writes", 64'(bw2_cnt), 64'd256);
    check("s256_bad", 64'(bw2_bad), 64'd0);
    check("s256_done_cnt", 64'(done2_cnt), 64'd1);
    check("s256_idle", 64'(busy2), 64'd0);

    // Load with M2 held low: timeout at M2_TMO+3 = 258
    m2_run = 1'b0; m2_lvl = 1'b0;
    repeat (4) @(negedge clk);
    pulse_load();
    e = 1;
    while (!err && e < 1000) begin @(negedge clk); e++; end
    check("tmo_cycles", 64'(e), 64'd258);
    check("tmo_done", 64'(done), 64'd1);
    check("tmo_we_low", 64'({ss_we, busy}), 64'd0);
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", 64'(err), 64'd1);
    pulse_save();
    check("tmo_err_clear", 64'(err), 64'd0);
    e = 1;
    while (!done && e < 2000) begin @(negedge clk); e++; end
    repeat (3) @(negedge clk);

    // Simultaneous starts run save; a load pulse while busy is ignored
    d0 = done_cnt; b0 = bw_cnt; w0 = we_rises;
    @(negedge clk); start_save = 1'b1; start_load = 1'b1;
    @(negedge clk); start_save = 1'b0; start_load = 1'b0;
    e = 1;
    while (!done && e < 2000) begin
      start_load = (e == 10);
      @(negedge clk);
      e++;
    end
    start_load = 1'b0;
    check("coll_cycles", 64'(e), 64'd385);
    repeat (3) @(negedge clk);
    check("coll_bw_cnt", 64'(bw_cnt - b0), 64'd128);
    check("coll_no_we", 64'(we_rises - w0), 64'd0);
    check("coll_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("coll_no_queue", 64'(busy), 64'd0);

    // Load of addr+1 with M2 running
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 8'(a); pre_dat = 8'(a + 1);
    end
    @(negedge clk); pre_we = 1'b0;
    m2_run = 1'b1;
    repeat (4) @(negedge clk);
    mw0 = map_writes; d0 = done_cnt;
    mon_load = 1'b1;
    pulse_load();
    e = 1;
    while (!done && e < 5000) begin @(negedge clk); e++; end
    check("load_done", 64'(done), 64'd1);
    check("load_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    mon_load = 1'b0;
    check("load_map_writes", 64'(map_writes - mw0), 64'd128);
    bad = 0;
    for (int a = 0; a < 128; a++) if (map_mem[8'(a)] !== 8'(a + 1)) bad++;
    check("load_map_bad", 64'(bad), 64'd0);
    check("load_map0", 64'(map_mem[0]), 64'h01);
    check("load_map127", 64'(map_mem[127]), 64'h80);
    check("load_stable", 64'(stab_viol), 64'd0);
    check("load_we_window", 64'(win_viol), 64'd0);
    check("load_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Reset while writing address 40
    d0 = done_cnt;
    pulse_load();
    e = 1;
    while (!(ss_we && ss_addr == 8'd40) && e < 5000) begin @(negedge clk); e++; end
    check("rst_reach40", 64'({ss_we, ss_addr}), 64'h128);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outs", 64'({ss_we, ss_act, busy}), 64'd0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_done", 64'(done_cnt - d0), 64'd0);
    check("rst_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
